// File: rtl/y_stream_capture_if.sv
// rtl/y_stream_capture_if.sv - assembled-word valid/ready handshake bundle (word_parity with Y_CAPTURE_PARITY_EN)
interface y_stream_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
`ifdef Y_CAPTURE_PARITY_EN
    logic             word_parity;
`endif

    modport master (
        input  word_ready,
        output word_out,
        output word_valid
`ifdef Y_CAPTURE_PARITY_EN
        , output word_parity
`endif
    );

    modport slave (
        output word_ready,
        input  word_out,
        input  word_valid
`ifdef Y_CAPTURE_PARITY_EN
        , input word_parity
`endif
    );
endinterface

// File: rtl/y_stream_capture.sv
// rtl/y_stream_capture.sv - serial y capture: MSB-first word packing, rise counter, pattern match
// Optional word_parity output when Y_CAPTURE_PARITY_EN is defined.
module y_stream_capture #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 y_in,
    input  logic                 en,
    input  logic [WIDTH-1:0]     pattern,
    y_stream_capture_if.master   word_if,
    output logic                 overflow,
    output logic                 match,
    output logic [CNT_W-1:0]     rise_count
);
    localparam int CW = $clog2(WIDTH);
    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [FW-1:0] FULL = FW'(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] window;
    logic [CW-1:0]    bit_cnt;
    logic [FW-1:0]    fill_cnt;
    logic             prev_bit;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;

    logic [WIDTH-1:0] word_c;
    logic [WIDTH-1:0] window_nx;
    logic [FW-1:0]    fill_nx;
    logic             complete;
    logic             load;
    logic             consume;
    logic             drop;
    logic             rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = SHIFT;
            SHIFT:   if (complete) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A word completes only from SHIFT; WIDTH >= 2 keeps the first sample in IDLE.
    always_comb begin
        word_c    = {shreg[WIDTH-2:0], y_in};
        complete  = en && (state == SHIFT) && (bit_cnt == LAST);
        consume   = valid_q && word_if.word_ready;
        load      = complete && (!valid_q || word_if.word_ready);
        drop      = complete && valid_q && !word_if.word_ready;
        rise      = en && !prev_bit && y_in;
        window_nx = {window[WIDTH-2:0], y_in};
        fill_nx   = (fill_cnt == FULL) ? fill_cnt : fill_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            prev_bit   <= 1'b0;
            window     <= '0;
            fill_cnt   <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            overflow   <= 1'b0;
            match      <= 1'b0;
            rise_count <= '0;
        end else begin
            if (en) begin
                shreg    <= word_c;
                bit_cnt  <= complete ? '0 : bit_cnt + 1'b1;
                prev_bit <= y_in;
                window   <= window_nx;
                fill_cnt <= fill_nx;
            end
            match <= en && (fill_nx == FULL) && (window_nx == pattern);
            if (load) begin
                word_q  <= word_c;
                valid_q <= 1'b1;
            end else if (consume && !complete) begin
                valid_q <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (rise && (rise_count != {CNT_W{1'b1}})) begin
                rise_count <= rise_count + 1'b1;
            end
        end
    end

    assign word_if.word_out   = word_q;
    assign word_if.word_valid = valid_q;

`ifdef Y_CAPTURE_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^word_c;
        end
    end

    assign word_if.word_parity = parity_q;
`endif
endmodule

// File: doc/y_stream_capture.md
Name: y_stream_capture

Overview:
- Downstream consumer of the single-bit `y` output of the 3-flip-flop dataflow state machine.
- Samples the serial stream on enabled cycles and packs it MSB-first into WIDTH-bit words.
- Hands each completed word out over a one-deep valid/ready output buffer.
- Also counts 0->1 transitions and flags a programmable sliding-window pattern match.

Parameters:
- WIDTH, 8, bits per assembled word and pattern length (>= 2)
- CNT_W, 16, width of the saturating rising-edge counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 at a clk edge clears all state)
- y_in  input  1  serial bit from the upstream dataflow state machine output `y`
- en  input  1  sample enable; y_in is sampled only on edges where en==1
- pattern  input  WIDTH  match pattern, compared against the most recent WIDTH samples
- word_out  output  WIDTH  assembled word; first-sampled bit in the MSB
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  consumer accepts word_out on an edge where word_valid && word_ready
- overflow  output  1  sticky: a completed word was dropped
- match  output  1  one-cycle pulse on a pattern match
- rise_count  output  CNT_W  number of sampled 0->1 transitions, saturating

Behaviour:
- Reset (reset==0 at an edge) clears everything, regardless of en or handshake state:
  - word_out=0, word_valid=0, overflow=0, match=0, rise_count=0
  - shreg=0, bit_cnt=0, prev_bit=0, window=0, fill_cnt=0, state=IDLE
  - A reset mid-word discards the partial word.
- FSM:
  - IDLE (bit_cnt==0, no partial word) -> SHIFT on an enabled sample when WIDTH>1.
  - SHIFT (partial word) -> IDLE on the edge capturing the WIDTH-th bit.
  - en==0 in SHIFT: pause; shreg and bit_cnt hold, no timeout.
- Sampling (edge with en==1):
  - shreg <= {shreg[WIDTH-2:0], y_in}; bit_cnt++.
  - On the WIDTH-th bit the completed word is C = {shreg[WIDTH-2:0], y_in}, and bit_cnt <= 0.
- Output buffer, on the edge that completes C:
  - word_valid==0 -> word_out<=C, word_valid<=1.
  - word_valid==1 && word_ready==1 -> old word consumed, word_out<=C, word_valid stays 1, no overflow.
  - word_valid==1 && word_ready==0 -> C dropped, word_out holds, overflow<=1 (sticky until reset).
- Output buffer, on edges with no completion: word_valid && word_ready -> word_valid<=0; word_out holds its value.
- Latency: word_valid rises on the edge that samples the last bit.
- Edge counter: enabled sample with prev_bit==0 && y_in==1 -> rise_count++, saturating at all-ones. prev_bit <= y_in on every enabled sample.
- Match:
  - window is a separate WIDTH-bit sliding register, updated on every enabled sample and ignoring word boundaries.
  - fill_cnt saturates at WIDTH.
  - match <= 1 for exactly one cycle when, after the update, fill_cnt==WIDTH and window==pattern; otherwise match <= 0.
  - No samples -> match=0.
- Pattern change takes effect on the next compare; pattern is not registered.

Optional Feature:
- Macro: Y_CAPTURE_PARITY_EN.
- Defined:
  - Adds output port word_parity (1 bit) = XOR of the completed word.
  - Registered together with word_out on the same load edge; holds with word_out; reset value 0.
  - A dropped word does not update it.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then en=1 with y_in = 0,1,1,0 repeating, word_ready=1 (WIDTH=8):
  - word_valid rises on the 8th sample edge with word_out=8'h66.
  - A second 8'h66 arrives after 8 more samples.
  - rise_count=4 after 16 samples; overflow=0.
- Same stream with word_ready=0 for 16 samples: first word 8'h66 held, overflow=1 after the 16th sample. Then word_ready=1 for one cycle -> word_valid=0 next edge.
- en toggled 1,0,1,0,... over a 0,1,1,0 stream (y_in advances only on enabled cycles): word 8'h66 still assembled after 16 cycles; shreg frozen during en==0 cycles.
- pattern=8'h66 with a continuous 0,1,1,0 stream:
  - No match before the 8th sample.
  - match pulses at samples 8, 12, 16 (window aligned across word boundaries), each one cycle wide.
- reset=0 asserted after 5 samples: all outputs 0 next edge; following 8 samples yield a fresh word, not merged with the discarded bits.
- CNT_W=2, 10 rising edges: rise_count saturates at 3. With Y_CAPTURE_PARITY_EN, word 8'h66 -> word_parity=0 and word 8'h67 -> word_parity=1.
